crc_decoder: RTL and testbench
==============================

CRC_DECODER -- requirements
Module: crc_decoder

Interface
REQ-001 Parameter INPUT_BITS, default 20, received codeword width: data bits followed by 4 CRC bits, MSB first; legal range is 5 or more.
REQ-002 Derived constant OUTPUT_BITS = INPUT_BITS-4, the recovered data width; it is not user-overridable.
REQ-003 One clock; reset is synchronous and active-low: port clk is the clock and port start is the reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 start  input  1  synchronous active-low reset; high = run a decode, low = clear and hold idle.
REQ-006 InputData  input  INPUT_BITS  codeword; bit INPUT_BITS-1 is the first bit processed, bits [3:0] are the CRC.
REQ-007 Ready  output  1  high when the decode is complete.
REQ-008 valid  output  1  high when Ready is high and the CRC remainder is zero.
REQ-009 OutputData  output  OUTPUT_BITS  equals InputData[INPUT_BITS-1:4] once Ready is high.

Function
REQ-010 CRC is CRC-4 with generator x^4+x+1 (binary 10011) and initial remainder 0000; there is no reflection and no final XOR.
REQ-011 Decoding is bit-serial, one codeword bit per clock, MSB first, by polynomial long division over the whole INPUT_BITS codeword.
REQ-012 States:
- RUN: entered on the first rising edge with start high.
- DONE: entered after the INPUT_BITS-th bit is processed.
- Idle/reset is forced whenever start is low.
REQ-013 While start is low, each edge loads InputData into an internal shift register, clears the bit counter and the remainder, and drives Ready=0, valid=0, OutputData=0.
REQ-014 In RUN, each edge shifts one bit into the 4-bit remainder:
- fb = rem[3] XOR bit
- rem <= {rem[2:0],0} XOR (fb ? 0011 : 0000)
- counter increments.
REQ-015 InputData changes after the last start-low edge are ignored for the current decode.
REQ-016 Latency: Ready rises on exactly the INPUT_BITS-th rising edge with start high (edge 20 at default); Ready is low on all earlier edges.
REQ-017 In DONE, Ready, valid and OutputData hold constant while start stays high; no further bits are processed.
REQ-018 valid = (final remainder == 0000), registered together with Ready.
REQ-019 start dropping low mid-decode or in DONE aborts the decode and applies REQ-013 on that edge; a new decode begins when start returns high.

Reset
REQ-020 The reset values are Ready=0, valid=0, OutputData=0, remainder=0 and counter=0, all synchronous to clk.
REQ-021 There is no asynchronous reset path; outputs are undefined only before the first clock edge.

Structure
REQ-022 A shared package holds CRC_WIDTH=4, the polynomial constant 4'b0011 (low terms of 10011) and the state encoding.
REQ-023 The per-bit remainder update is one combinational sub-module, crc4_step (inputs rem and bit, output next rem).
REQ-024 The counter width is sized by $clog2(INPUT_BITS+1).

Verification
REQ-025 Clean word: InputData=1000_0000_0100_0010_0010, start high after one low edge -> edge 20: Ready=1, valid=1, OutputData=0x8042; Ready=0 on edges 1-19.
REQ-026 CRC bit error: InputData=1000_0000_0100_0010_0011 -> edge 20: Ready=1, valid=0 (remainder 0001), OutputData=0x8042.
REQ-027 Data bit error: InputData=0000_0000_0100_0010_0010 -> edge 20: Ready=1, valid=0 (remainder 0011), OutputData=0x0042.
REQ-028 Abort: drop start at edge 10, raise it again at edge 12 with the clean word -> Ready stays 0, then Ready=1 and valid=1 exactly 20 edges after restart.
REQ-029 Hold and input isolation: after DONE, keep start high 10 more edges while changing InputData -> outputs unchanged.
REQ-030 Zero word: InputData=0 -> edge 20: valid=1, OutputData=0.

Source files
------------

// File: rtl/crc_decoder_pkg.sv
// Shared constants and state encoding for the bit-serial CRC-4 decoder.
// Generator is x^4+x+1; only the low terms are stored because the x^4 term is implicit.
package crc_decoder_pkg;

  localparam int CRC_WIDTH = 4;
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One step of MSB-first long division: shift the remainder, fold the poly in on feedback.
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] rem,
                                                    input logic bit_in);
    logic fb;
    fb = rem[CRC_WIDTH-1] ^ bit_in;
    return {rem[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc_decoder_if.sv
// Codeword in, decode status and recovered data out, plus the FSM state for observation.
// Ready/valid are a completion/status pair, not flow control: Ready=1 means the result
// is final and held; valid qualifies the CRC check and is only meaningful while Ready=1.
interface crc_decoder_if #(
  parameter int INPUT_BITS = 20
);
  import crc_decoder_pkg::*;

  localparam int OUTPUT_BITS = INPUT_BITS - CRC_WIDTH;

  logic [INPUT_BITS-1:0]  InputData;
  logic                   Ready;
  logic                   valid;
  logic [OUTPUT_BITS-1:0] OutputData;
  state_t                 state;

  modport master (
    output InputData,
    input  Ready,
    input  valid,
    input  OutputData,
    input  state
  );

  modport slave (
    input  InputData,
    output Ready,
    output valid,
    output OutputData,
    output state
  );

endinterface

// File: rtl/crc_decoder_step.sv
// Combinational per-bit remainder update for the CRC-4 divider.
module crc4_step
  import crc_decoder_pkg::*;
(
  input  logic [CRC_WIDTH-1:0] rem,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] rem_next
);

  assign rem_next = crc_step(rem, bit_in);

endmodule

// File: rtl/crc_decoder.sv
// Bit-serial CRC-4 decoder: start low loads the codeword and clears; start high divides one
// bit per clock, MSB first, and raises Ready on the INPUT_BITS-th edge.
module crc_decoder
  import crc_decoder_pkg::*;
#(
  parameter int INPUT_BITS = 20
) (
  input logic           clk,
  input logic           start,
  crc_decoder_if.slave  bus
);

  localparam int OUTPUT_BITS = INPUT_BITS - CRC_WIDTH;
  localparam int CNT_W       = $clog2(INPUT_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_BITS - 1);

  state_t                 state_q, state_d;
  logic [INPUT_BITS-1:0]  shreg_q, shreg_d;
  logic [INPUT_BITS-1:0]  data_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CRC_WIDTH-1:0]   rem_q, rem_d, rem_step;
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic [OUTPUT_BITS-1:0] out_q, out_d;

  crc4_step u_step (
    .rem      (rem_q),
    .bit_in   (shreg_q[INPUT_BITS-1]),
    .rem_next (rem_step)
  );

  // data_q is a private copy so later InputData changes cannot reach OutputData.
  always_ff @(posedge clk) begin
    if (!start) begin
      state_q <= ST_IDLE;
      shreg_q <= bus.InputData;
      data_q  <= bus.InputData;
      cnt_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ready_d = ready_q;
    valid_d = valid_q;
    out_d   = out_q;
    unique case (state_q)
      // IDLE already consumes a bit so the first start-high edge counts as bit one.
      ST_IDLE, ST_RUN: begin
        rem_d   = rem_step;
        shreg_d = {shreg_q[INPUT_BITS-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          valid_d = (rem_step == '0);
          out_d   = data_q[INPUT_BITS-1:CRC_WIDTH];
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.Ready      = ready_q;
  assign bus.valid      = valid_q;
  assign bus.OutputData = out_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_crc_decoder.sv
// Self-checking bench for crc_decoder: directed codewords plus random ones, against a
// polynomial long-division model.
module tb_crc_decoder;
  import crc_decoder_pkg::*;

  localparam int IB = 20;
  localparam int OB = IB - 4;
  localparam logic [IB-1:0] CLEAN_WORD = 20'b1000_0000_0100_0010_0010;

  logic clk   = 1'b0;
  logic start = 1'b0;

  crc_decoder_if #(.INPUT_BITS(IB)) bus ();

  crc_decoder #(.INPUT_BITS(IB)) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [OB:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Remainder of the codeword polynomial divided by x^4+x+1, by schoolbook long division.
  function automatic logic [3:0] poly_mod(input logic [IB-1:0] w);
    logic [IB-1:0] r;
    logic [IB-1:0] g;
    r = w;
    for (int i = IB - 1; i >= 4; i--) begin
      if (r[i]) begin
        g = IB'(5'b10011) << (i - 4);
        r = r ^ g;
      end
    end
    return r[3:0];
  endfunction

  function automatic logic [IB-1:0] make_clean(input logic [OB-1:0] data);
    logic [IB-1:0] w;
    w = {data, 4'b0000};
    w[3:0] = poly_mod(w);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IB-1:0] w);
    start = 1'b0;
    bus.InputData = w;
    tick();
    check("rst_ready", 32'(bus.Ready), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data",  32'(bus.OutputData), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
  endtask

  task automatic run(input logic [IB-1:0] w, input bit scramble, output logic [OB:0] e);
    exp_q.push_back({poly_mod(w) == 4'd0, w[IB-1:4]});
    start = 1'b1;
    for (int k = 1; k <= IB; k++) begin
      if (scramble) bus.InputData = IB'($urandom);
      tick();
      if (k < IB) check("ready_early", 32'(bus.Ready), 32'd0);
    end
    e = exp_q.pop_front();
    check("ready_done", 32'(bus.Ready), 32'd1);
    check("valid",      32'(bus.valid), 32'(e[OB]));
    check("data",       32'(bus.OutputData), 32'(e[OB-1:0]));
    check("state_done", 32'(bus.state), 32'(ST_DONE));
  endtask

  task automatic decode(input logic [IB-1:0] w, input bit scramble, output logic [OB:0] e);
    load(w);
    run(w, scramble, e);
  endtask

  task automatic hold(input int n, input logic [OB:0] e);
    for (int k = 0; k < n; k++) begin
      bus.InputData = IB'($urandom);
      tick();
      check("hold_ready", 32'(bus.Ready), 32'd1);
      check("hold_valid", 32'(bus.valid), 32'(e[OB]));
      check("hold_data",  32'(bus.OutputData), 32'(e[OB-1:0]));
    end
  endtask

  initial begin
    logic [OB:0]   e;
    logic [IB-1:0] w;

    bus.InputData = '0;

    // Directed words, including independent checks of the documented results.
    decode(CLEAN_WORD, 1'b0, e);
    check("clean_valid_abs", 32'(bus.valid), 32'd1);
    check("clean_data_abs",  32'(bus.OutputData), 32'h8042);
    hold(10, e);

    decode(20'b1000_0000_0100_0010_0011, 1'b0, e);
    check("crcerr_valid_abs", 32'(bus.valid), 32'd0);
    check("crcerr_data_abs",  32'(bus.OutputData), 32'h8042);

    decode(20'b0000_0000_0100_0010_0010, 1'b0, e);
    check("dataerr_valid_abs", 32'(bus.valid), 32'd0);
    check("dataerr_data_abs",  32'(bus.OutputData), 32'h0042);

    decode('0, 1'b0, e);
    check("zero_valid_abs", 32'(bus.valid), 32'd1);
    check("zero_data_abs",  32'(bus.OutputData), 32'd0);

    // Abort: start high edges 1-9, low on edges 10-11, high again from edge 12.
    load(CLEAN_WORD);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("abort_ready_pre", 32'(bus.Ready), 32'd0);
    end
    start = 1'b0;
    for (int k = 10; k <= 11; k++) begin
      tick();
      check("abort_ready_low", 32'(bus.Ready), 32'd0);
      check("abort_state",     32'(bus.state), 32'(ST_IDLE));
    end
    run(CLEAN_WORD, 1'b1, e);
    check("abort_valid_abs", 32'(bus.valid), 32'd1);

    // Abort from DONE clears outputs on that edge.
    load(20'hFFFFF);

    // Random words: half made clean, half arbitrary; input scrambled during the decode.
    for (int t = 0; t < 30; t++) begin
      if (t % 2 == 0) w = make_clean(OB'($urandom));
      else            w = IB'($urandom);
      decode(w, $urandom_range(0, 1) == 1, e);
      if ($urandom_range(0, 3) == 0) hold($urandom_range(1, 4), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
